// File: rtl/bitstream_pkg.sv
// -----------------------------------------------------------------------------
// bitstream_pkg
//
// Shared definitions for the bitstream serializer:
//   state_t              - serializer FSM states (IDLE, SHIFT, GAP)
//   DEFAULT_GAP_CYCLES   - default number of idle cycles after each frame
//   DEFAULT_IDLE_BIT     - default dout level when no frame bit is valid
//   GAP_COUNT_WIDTH      - width of the inter-frame gap counter (0..15)
//   bit_count_width()    - width of the frame bit counter for a given word width
// -----------------------------------------------------------------------------
package bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_GAP_CYCLES = 0;
    localparam bit DEFAULT_IDLE_BIT   = 1'b0;

    // GAP_CYCLES is limited to 0..15, so four bits always hold GAP_CYCLES-1.
    localparam int GAP_COUNT_WIDTH = 4;

    // One spare bit above what WIDTH+1 needs, so the counter holds the longest
    // frame (data plus an optional parity bit) without any risk of overflow.
    function automatic int bit_count_width(input int width);
        return $clog2(width + 1) + 1;
    endfunction

endpackage

// File: rtl/bitstream_bit_counter.sv
// -----------------------------------------------------------------------------
// bitstream_bit_counter
//
// Loadable down-counter with a zero flag. Used by the serializer both for the
// remaining bits of a frame and for the idle cycles after a frame.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset, clears the count
//   load        - load load_value (has priority over dec)
//   load_value  - value to load
//   dec         - decrement by one; ignored once the count is zero (no wrap)
//   count       - current count
//   zero        - count equals zero
// -----------------------------------------------------------------------------
module bitstream_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    assign zero = (count == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/bitstream_serializer.sv
// -----------------------------------------------------------------------------
// bitstream_serializer
//
// Parallel-to-serial converter with a valid/ready word interface. A word is
// accepted on a rising edge where data_valid and data_ready are both high; its
// first bit appears on dout one cycle later, one bit per cycle, followed by
// GAP_CYCLES idle cycles. With GAP_CYCLES == 0 a new word can be accepted
// during the last bit of the current frame, giving gap-free back-to-back frames.
//
// Optional feature (compile-time macro BITSTREAM_SERIALIZER_PARITY_EN):
//   appends one even-parity bit (XOR of all data bits) after the data bits;
//   frame_done then marks the parity bit instead of the last data bit.
//
// Parameters:
//   WIDTH       - parallel word width, 2..32
//   MSB_FIRST   - 1: bit WIDTH-1 sent first, 0: bit 0 sent first
//   GAP_CYCLES  - idle cycles after every frame, 0..15
//   IDLE_BIT    - dout level whenever no frame bit is valid
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset; aborts any frame in progress
//   data_in     - parallel word to serialize
//   data_valid  - data_in holds a word for transfer
//   data_ready  - serializer accepts a word this cycle (combinational from state)
//   dout        - serial bit stream (registered)
//   dout_valid  - dout carries a frame bit (registered)
//   frame_done  - one-cycle pulse with the last bit of a frame (registered)
//   busy        - high while shifting or in the inter-frame gap
// -----------------------------------------------------------------------------
module bitstream_serializer
    import bitstream_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter bit IDLE_BIT   = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             busy
);

`ifdef BITSTREAM_SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_LEN = WIDTH + PARITY_BITS;
    localparam int CW        = bit_count_width(WIDTH);
    localparam bit HAS_GAP   = (GAP_CYCLES > 0);

    // The bit counter holds the number of frame bits still to come after the
    // one currently on dout, so it reads zero while the last bit is shown.
    localparam logic [CW-1:0] BIT_LOAD  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(1);

    // The gap counter reads zero during the final gap cycle.
    localparam logic [GAP_COUNT_WIDTH-1:0] GAP_LOAD =
        GAP_COUNT_WIDTH'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic             transfer;

    logic             bit_load;
    logic             bit_dec;
    logic [CW-1:0]    bit_count;
    logic             bit_zero;

    logic             gap_load;
    logic             gap_dec;
    logic             gap_zero;
    logic [GAP_COUNT_WIDTH-1:0] gap_count_unused;

`ifdef BITSTREAM_SERIALIZER_PARITY_EN
    logic             parity_bit;
`endif

    // Bit that leaves the shift register next, and the register after it left.
    function automatic logic first_bit(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? word[WIDTH-1] : word[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
    endfunction

    // ------------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------------
    // Without a gap the next word is taken while the last bit is on the line,
    // which is what keeps back-to-back frames contiguous.
    assign data_ready = (state == IDLE) ||
                        ((state == SHIFT) && bit_zero && !HAS_GAP);
    assign transfer   = data_valid && data_ready;
    assign busy       = (state != IDLE);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        bit_load   = 1'b0;
        bit_dec    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = SHIFT;
                    bit_load   = 1'b1;
                end
            end
            SHIFT: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                end else if (transfer) begin
                    bit_load = 1'b1;
                end else if (HAS_GAP) begin
                    state_next = GAP;
                    gap_load   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_next = IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    bitstream_bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (bit_load),
        .load_value (BIT_LOAD),
        .dec        (bit_dec),
        .count      (bit_count),
        .zero       (bit_zero)
    );

    bitstream_bit_counter #(
        .CW (GAP_COUNT_WIDTH)
    ) u_gap_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .dec        (gap_dec),
        .count      (gap_count_unused),
        .zero       (gap_zero)
    );

    // ------------------------------------------------------------------------
    // Datapath: shift register and registered outputs
    // ------------------------------------------------------------------------
    // The first bit goes straight to dout at the transfer edge; the shift
    // register keeps only the bits that have not been sent yet.
    //
    // NOTE: the shift register is reset along with the control state; it is a
    // handful of flops rather than a memory array, so clearing it costs nothing
    // and keeps a post-reset dump free of stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
`ifdef BITSTREAM_SERIALIZER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (bit_load) begin
                dout       <= first_bit(data_in);
                dout_valid <= 1'b1;
                shreg      <= advance(data_in);
`ifdef BITSTREAM_SERIALIZER_PARITY_EN
                parity_bit <= ^data_in;
`endif
            end else if (bit_dec) begin
                dout_valid <= 1'b1;
                frame_done <= (bit_count == LAST_STEP);
`ifdef BITSTREAM_SERIALIZER_PARITY_EN
                dout       <= (bit_count == LAST_STEP) ? parity_bit : first_bit(shreg);
`else
                dout       <= first_bit(shreg);
`endif
                shreg      <= advance(shreg);
            end else begin
                dout       <= IDLE_BIT;
                dout_valid <= 1'b0;
            end
        end
    end

endmodule
